// File: rtl/ckong_dl_router_if.sv
// ckong_dl_router_if: ioctl download stream in, registered ROM-load bus out
//   master: drives ioctl_download/ioctl_wr/ioctl_addr/ioctl_dout, observes dn_*
//   slave : consumes ioctl_*, drives dn_addr/dn_data/dn_wr/dn_region
interface ckong_dl_router_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [16:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic [1:0]  dn_region;
  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
    input  dn_addr, dn_data, dn_wr, dn_region
  );
  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
    output dn_addr, dn_data, dn_wr, dn_region
  );
endinterface

// File: rtl/ckong_dl_router.sv
// ckong_dl_router: qualifies/registers ioctl ROM bytes for the ckong core, holds core reset, checks image
//   clk_sys, reset (async, active-high) | bus: ioctl_* in, dn_* out (1-cycle latency)
//   cpu_reset_hold: high in LOAD/TAIL | byte_count: saturating accepted count | overflow: sticky out-of-range
//   rom_ok: image complete and clean, valid in DONE | dl_done: one-cycle pulse entering DONE
module ckong_dl_router #(
  parameter logic [16:0] ROM_SIZE    = 17'h10000,
  parameter logic [16:0] CPU_END     = 17'h06000,
  parameter logic [16:0] GFX_END     = 17'h0E000,
  parameter int          HOLD_CYCLES = 16
) (
  input  logic               clk_sys,
  input  logic               reset,
  ckong_dl_router_if.slave   bus,
  output logic               cpu_reset_hold,
  output logic [16:0]        byte_count,
  output logic               overflow,
  output logic               rom_ok,
  output logic               dl_done
);
  typedef enum logic [1:0] {IDLE, LOAD, TAIL, DONE} state_t;
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  state_t      state;
  logic [7:0]  hold_cnt;
  logic [1:0]  rst_q;
  logic        rst_i;
  logic        accept;
  logic        oob;
  logic        in_range;
  logic        start;
  logic [1:0]  region;
  // Reset asserts immediately but is released only after two clk_sys edges.
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) rst_q <= 2'b11;
    else rst_q <= {rst_q[0], 1'b0};
  assign rst_i    = rst_q[1];
  assign accept   = bus.ioctl_wr & bus.ioctl_download;
  assign oob      = bus.ioctl_addr >= {8'd0, ROM_SIZE};
  assign in_range = accept & ~oob;
  // Download high outside LOAD starts a fresh load, including a re-rise during TAIL.
  assign start    = bus.ioctl_download & (state != LOAD);
  assign region   = bus.ioctl_addr[16:0] < CPU_END ? 2'd0 : bus.ioctl_addr[16:0] < GFX_END ? 2'd1 : 2'd2;
  always_ff @(posedge clk_sys or posedge rst_i)
    if (rst_i) begin
      state          <= IDLE;
      hold_cnt       <= '0;
      cpu_reset_hold <= 1'b0;
      byte_count     <= '0;
      overflow       <= 1'b0;
      rom_ok         <= 1'b0;
      dl_done        <= 1'b0;
      bus.dn_wr      <= 1'b0;
      bus.dn_addr    <= '0;
      bus.dn_data    <= '0;
      bus.dn_region  <= '0;
    end else begin
      bus.dn_wr <= in_range;
      dl_done   <= 1'b0;
      if (in_range) begin
        bus.dn_addr   <= bus.ioctl_addr[16:0];
        bus.dn_data   <= bus.ioctl_dout;
        bus.dn_region <= region;
      end
      if (start) begin
        state          <= LOAD;
        hold_cnt       <= '0;
        cpu_reset_hold <= 1'b1;
        byte_count     <= {16'd0, in_range};
        overflow       <= accept & oob;
        rom_ok         <= 1'b0;
      end else if (state == LOAD) begin
        if (in_range && byte_count != '1) byte_count <= byte_count + 17'd1;
        if (accept && oob) overflow <= 1'b1;
        if (!bus.ioctl_download) begin
          state    <= TAIL;
          hold_cnt <= '0;
        end
      end else if (state == TAIL) begin
        if (hold_cnt == HOLD_LAST) begin
          state          <= DONE;
          cpu_reset_hold <= 1'b0;
          dl_done        <= 1'b1;
          rom_ok         <= (byte_count == ROM_SIZE) & ~overflow;
        end else hold_cnt <= hold_cnt + 8'd1;
      end
    end
endmodule
